// File: rtl/ttc_pkg.sv
// Shared types, limits and helpers for the truth-table capture block.
package ttc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } ttc_state_e;

  localparam int unsigned NInputsMin = 1;
  localparam int unsigned NInputsMax = 8;
  localparam int unsigned SettleMin  = 1;
  localparam int unsigned SettleMax  = 255;

  function automatic int unsigned ttc_table_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/ttc_vector_sequencer.sv
// Settle counter and vector index counter; emits the stimulus and sample strobes.
module ttc_vector_sequencer
  import ttc_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_run,
  output logic [N_INPUTS-1:0] o_stim,
  output logic                o_sample,
  output logic                o_early_sample,
  output logic                o_last
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntTerm  = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntEarly = CntW'(SETTLE_CYCLES - 1);
  // One extra index bit so the post-last increment cannot alias back to vector 0.
  localparam logic [N_INPUTS:0] IdxLast = (N_INPUTS + 1)'(ttc_table_w(N_INPUTS) - 1);

  logic [CntW-1:0]   r_cnt;
  logic [N_INPUTS:0] r_idx;
  logic              w_term;

  assign w_term = (r_cnt == CntTerm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_run) begin
      if (w_term) begin
        r_cnt <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stim         = i_run ? r_idx[N_INPUTS-1:0] : '0;
  assign o_sample       = i_run && w_term;
  assign o_early_sample = i_run && (r_cnt == CntEarly);
  assign o_last         = (r_idx == IdxLast);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all input vectors of a combinational block and captures its truth table.
// Optional feature macro: TTC_DOUBLE_SAMPLE_EN (second, earlier sample flags unstable responses).
module truth_table_capture
  import ttc_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic [N_INPUTS-1:0]                  stim,
  input  logic                                 resp,
  output logic                                 busy,
  output logic                                 done,
  output logic [ttc_table_w(N_INPUTS)-1:0]     table_out,
  output logic                                 table_valid,
  output logic                                 unstable
);

  localparam int unsigned TableW = ttc_table_w(N_INPUTS);

  if (N_INPUTS < NInputsMin || N_INPUTS > NInputsMax) begin : g_bad_n_inputs
    $error("N_INPUTS out of range");
  end
  if (SETTLE_CYCLES < SettleMin || SETTLE_CYCLES > SettleMax) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range");
  end

  ttc_state_e r_state, w_state_d;

  logic [TableW-1:0]   r_acc;
  logic [TableW-1:0]   r_table_out;
  logic [TableW-1:0]   w_table;
  logic                r_table_valid;
  logic [N_INPUTS-1:0] w_stim;
  logic                w_sample;
  logic                w_early_sample;
  logic                w_last;
  logic                w_accept;
  logic                w_capture;
  logic                w_finish;

  ttc_vector_sequencer #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (w_accept),
    .i_run          (r_state == StDrive),
    .o_stim         (w_stim),
    .o_sample       (w_sample),
    .o_early_sample (w_early_sample),
    .o_last         (w_last)
  );

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_finish  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StDrive;
          w_accept  = 1'b1;
        end
      end
      StDrive: begin
        if (w_sample) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_d = StDone;
            w_finish  = 1'b1;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Partial table with the current response merged into the current vector's bit.
  always_comb begin
    w_table         = r_acc;
    w_table[w_stim] = resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_acc         <= '0;
      r_table_out   <= '0;
      r_table_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_acc         <= '0;
        r_table_valid <= 1'b0;
      end
      if (w_capture) begin
        r_acc <= w_table;
      end
      // Table is published on the last sample edge so it lines up with the DONE cycle.
      if (w_finish) begin
        r_table_out   <= w_table;
        r_table_valid <= 1'b1;
      end
    end
  end

`ifdef TTC_DOUBLE_SAMPLE_EN
  logic r_early;
  logic r_unstable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_early    <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      if (w_early_sample) begin
        r_early <= resp;
      end
      if (w_accept) begin
        r_unstable <= 1'b0;
      end else if (w_capture && (resp != r_early)) begin
        r_unstable <= 1'b1;
      end
    end
  end

  assign unstable = r_unstable;
`else
  logic w_unused_early;
  assign w_unused_early = w_early_sample;
  assign unstable       = 1'b0;
`endif

  assign stim        = w_stim;
  assign busy        = (r_state == StDrive);
  assign done        = (r_state == StDone);
  assign table_out   = r_table_out;
  assign table_valid = r_table_valid;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed self-checking bench for truth_table_capture (instances with S=1, S=3 and S=2).
module tb_truth_table_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tog = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  int         mode_a = 0, mode_b = 0, mode_c = 0;
  logic [2:0] stim_a, stim_b, stim_c;
  logic       resp_a, resp_b, resp_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] tbl_a, tbl_b, tbl_c;
  logic       valid_a, valid_b, valid_c;
  logic       unst_a, unst_b, unst_c;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  function automatic logic model(input int mode, input logic [2:0] s, input logic t);
    case (mode)
      0:       return 1'b1;
      1:       return s[0];
      2:       return &s;
      3:       return ^s;
      5:       return (s == 3'd5) ? t : s[0];
      default: return 1'b0;
    endcase
  endfunction

  assign resp_a = model(mode_a, stim_a, tog);
  assign resp_b = model(mode_b, stim_b, tog);
  assign resp_c = model(mode_c, stim_c, tog);

  truth_table_capture #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .resp(resp_a), .busy(busy_a),
    .done(done_a), .table_out(tbl_a), .table_valid(valid_a), .unstable(unst_a)
  );
  truth_table_capture #(.N_INPUTS(3), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .resp(resp_b), .busy(busy_b),
    .done(done_b), .table_out(tbl_b), .table_valid(valid_b), .unstable(unst_b)
  );
  truth_table_capture #(.N_INPUTS(3), .SETTLE_CYCLES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stim(stim_c), .resp(resp_c), .busy(busy_c),
    .done(done_c), .table_out(tbl_c), .table_valid(valid_c), .unstable(unst_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep; lat = edges from accept to done visible, bcnt = cycles busy was high.
  task automatic do_sweep(input int inst, input int mode, output int lat, output int bcnt,
                          output logic [7:0] tbl, output logic unst);
    logic d, b;
    case (inst)
      0: begin mode_a = mode; start_a = 1'b1; end
      1: begin mode_b = mode; start_b = 1'b1; end
      default: begin mode_c = mode; start_c = 1'b1; end
    endcase
    step();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lat = 0;
    bcnt = 0;
    d = 1'b0;
    while (!d && lat < 200) begin
      case (inst)
        0: b = busy_a;
        1: b = busy_b;
        default: b = busy_c;
      endcase
      if (b) bcnt++;
      step();
      lat++;
      case (inst)
        0: d = done_a;
        1: d = done_b;
        default: d = done_c;
      endcase
    end
    case (inst)
      0: begin tbl = tbl_a; unst = unst_a; end
      1: begin tbl = tbl_b; unst = unst_b; end
      default: begin tbl = tbl_c; unst = unst_c; end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++; if (stim_a !== 3'd0) $display("FAIL reset_stim got %h want 0", stim_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_total++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
    n_total++; if (tbl_a !== 8'h00) $display("FAIL reset_table got %h want 00", tbl_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_a); else n_pass++;
    n_total++; if (unst_a !== 1'b0) $display("FAIL reset_unstable got %b want 0", unst_a); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_const_one();
    int lat, bcnt;
    logic [7:0] t;
    logic u;
    do_sweep(0, 0, lat, bcnt, t, u);
    n_total++; if (lat !== 16) $display("FAIL ones_latency got %0d want 16", lat); else n_pass++;
    n_total++; if (bcnt !== 16) $display("FAIL ones_busy got %0d want 16", bcnt); else n_pass++;
    n_total++; if (t !== 8'hFF) $display("FAIL ones_table got %h want ff", t); else n_pass++;
    n_total++; if (valid_a !== 1'b1) $display("FAIL ones_valid got %b want 1", valid_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL ones_busy_at_done got %b want 0", busy_a); else n_pass++;
    step();
    n_total++; if (done_a !== 1'b0) $display("FAIL ones_done_pulse got %b want 0", done_a); else n_pass++;
  endtask

  task automatic test_bit_order();
    int lat, bcnt;
    logic [7:0] t;
    logic u;
    do_sweep(0, 1, lat, bcnt, t, u);
    n_total++; if (t !== 8'hAA) $display("FAIL order_inp3 got %h want aa", t); else n_pass++;
    step();
    do_sweep(0, 2, lat, bcnt, t, u);
    n_total++; if (t !== 8'h80) $display("FAIL order_and got %h want 80", t); else n_pass++;
    n_total++; if (lat !== 16) $display("FAIL order_latency got %0d want 16", lat); else n_pass++;
    step();
  endtask

  task automatic test_settle3();
    int lat, bcnt;
    logic [7:0] t;
    logic u;
    do_sweep(1, 3, lat, bcnt, t, u);
    n_total++; if (t !== 8'h96) $display("FAIL settle3_xor got %h want 96", t); else n_pass++;
    n_total++; if (lat !== 32) $display("FAIL settle3_latency got %0d want 32", lat); else n_pass++;
    n_total++; if (bcnt !== 32) $display("FAIL settle3_busy got %0d want 32", bcnt); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int lat, bcnt;
    logic [7:0] t;
    logic u;
    mode_a = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (stim_a !== 3'd0) $display("FAIL midrst_stim got %h want 0", stim_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_a); else n_pass++;
    n_total++; if (tbl_a !== 8'h00) $display("FAIL midrst_table got %h want 00", tbl_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid_a); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    do_sweep(0, 1, lat, bcnt, t, u);
    n_total++; if (t !== 8'hAA) $display("FAIL midrst_retable got %h want aa", t); else n_pass++;
    n_total++; if (lat !== 16) $display("FAIL midrst_latency got %0d want 16", lat); else n_pass++;
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    logic held_ok;
    mode_a = 2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    lat = 0;
    held_ok = 1'b1;
    while (!done_a && lat < 200) begin
      start_a = (lat == 5);
      if (tbl_a !== 8'hAA) held_ok = 1'b0;
      step();
      lat++;
    end
    start_a = 1'b0;
    n_total++; if (held_ok !== 1'b1) $display("FAIL ignore_held_table got %b want 1", held_ok); else n_pass++;
    n_total++; if (lat !== 16) $display("FAIL ignore_latency got %0d want 16", lat); else n_pass++;
    n_total++; if (tbl_a !== 8'h80) $display("FAIL ignore_table got %h want 80", tbl_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    // Still in the DONE cycle from the previous sweep: a start here must be dropped.
    mode_a = 0;
    start_a = 1'b1;
    step();
    n_total++; if (busy_a !== 1'b0) $display("FAIL b2b_done_start got %b want 0", busy_a); else n_pass++;
    step();
    start_a = 1'b0;
    n_total++; if (busy_a !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy_a); else n_pass++;
    lat = 0;
    while (!done_a && lat < 200) begin
      step();
      lat++;
    end
    n_total++; if (lat !== 16) $display("FAIL b2b_latency got %0d want 16", lat); else n_pass++;
    n_total++; if (tbl_a !== 8'hFF) $display("FAIL b2b_table got %h want ff", tbl_a); else n_pass++;
    step();
  endtask

  task automatic test_double_sample();
    int lat, bcnt;
    logic [7:0] t;
    logic u;
    logic exp_u;
`ifdef TTC_DOUBLE_SAMPLE_EN
    exp_u = 1'b1;
`else
    exp_u = 1'b0;
`endif
    do_sweep(2, 5, lat, bcnt, t, u);
    n_total++; if (u !== exp_u) $display("FAIL dbl_unstable got %b want %b", u, exp_u); else n_pass++;
    n_total++; if ((t & 8'hDF) !== 8'h8A) $display("FAIL dbl_table got %h want 8a|bit5", t); else n_pass++;
    n_total++; if (lat !== 24) $display("FAIL dbl_latency got %0d want 24", lat); else n_pass++;
    step();
    n_total++; if (unst_c !== exp_u) $display("FAIL dbl_sticky got %b want %b", unst_c, exp_u); else n_pass++;
    mode_c = 1;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    n_total++; if (unst_c !== 1'b0) $display("FAIL dbl_clear got %b want 0", unst_c); else n_pass++;
    lat = 0;
    while (!done_c && lat < 200) begin
      step();
      lat++;
    end
    n_total++; if (tbl_c !== 8'hAA) $display("FAIL dbl_retable got %h want aa", tbl_c); else n_pass++;
    n_total++; if (unst_c !== 1'b0) $display("FAIL dbl_stable got %b want 0", unst_c); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_bit_order();
    test_settle3();
    test_reset_mid_sweep();
    test_start_ignored();
    test_back_to_back();
    test_double_sample();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
